// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: IFU, LSU and memory signal bundle shared by the arbiter and its neighbours
interface mem_arbiter_if;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_resp_valid;
    logic [31:0] ifu_rdata;
    logic        ifu_resp_err;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic [31:0] lsu_addr;
    logic        lsu_we;
    logic [31:0] lsu_wdata;
    logic [2:0]  lsu_memop;
    logic        lsu_resp_valid;
    logic [31:0] lsu_rdata;
    logic        lsu_resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_op;
    logic        mem_wen;
    logic        mem_ren;
    logic [31:0] mem_rdata;
    modport slave (
        input  ifu_req_valid, ifu_addr, lsu_req_valid, lsu_addr, lsu_we, lsu_wdata, lsu_memop, mem_rdata,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
        output mem_addr, mem_wdata, mem_op, mem_wen, mem_ren
    );
    modport master (
        output ifu_req_valid, ifu_addr, lsu_req_valid, lsu_addr, lsu_we, lsu_wdata, lsu_memop, mem_rdata,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
        input  mem_addr, mem_wdata, mem_op, mem_wen, mem_ren
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the data memory between IFU and LSU with LSU priority and an IFU starvation guard
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input logic          clk,
    input logic          rst_n,
    mem_arbiter_if.slave bus
);
    typedef enum logic {IDLE, RESP} state_t;
    localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
    state_t      state, state_n;
    logic [3:0]  streak;
    logic        sel_ifu, err_q, load_q;
    logic        grant_ifu, grant_lsu, grant, grant_ok, issue, ifu_ok, lsu_ok, resp_on;
    logic [2:0]  op;
    assign op = bus.lsu_memop;
    assign ifu_ok = bus.ifu_addr[1:0] == 2'b00;
    // sign-extending/zero-extending variants are load-only; stores use 000/001/010
    assign lsu_ok = (op == 3'b000) | (op == 3'b100 & !bus.lsu_we)
                  | (op == 3'b001 & !bus.lsu_addr[0]) | (op == 3'b101 & !bus.lsu_addr[0] & !bus.lsu_we)
                  | (op == 3'b010 & bus.lsu_addr[1:0] == 2'b00);
    always_comb begin
        grant_ifu = rst_n && state == IDLE && bus.ifu_req_valid && (!bus.lsu_req_valid || streak == LIM);
        grant_lsu = rst_n && state == IDLE && bus.lsu_req_valid && !grant_ifu;
        grant = grant_ifu || grant_lsu;
        grant_ok = grant_ifu ? ifu_ok : lsu_ok;
        issue = grant && grant_ok;
        state_n = grant ? RESP : IDLE;
        resp_on = rst_n && state == RESP;
        bus.ifu_req_ready = grant_ifu;
        bus.lsu_req_ready = grant_lsu;
        bus.mem_addr = issue ? (grant_ifu ? bus.ifu_addr : bus.lsu_addr) : 32'h0;
        bus.mem_wdata = issue ? bus.lsu_wdata : 32'h0;
        bus.mem_op = issue ? (grant_ifu ? 3'b010 : op) : 3'b011;
        bus.mem_ren = issue && (grant_ifu || !bus.lsu_we);
        bus.mem_wen = issue && grant_lsu && bus.lsu_we;
        bus.ifu_resp_valid = resp_on && sel_ifu;
        bus.ifu_rdata = (resp_on && sel_ifu && load_q) ? bus.mem_rdata : 32'h0;
        bus.ifu_resp_err = resp_on && sel_ifu && err_q;
        bus.lsu_resp_valid = resp_on && !sel_ifu;
        bus.lsu_rdata = (resp_on && !sel_ifu && load_q) ? bus.mem_rdata : 32'h0;
        bus.lsu_resp_err = resp_on && !sel_ifu && err_q;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            streak <= 4'd0;
            sel_ifu <= 1'b0;
            err_q <= 1'b0;
            load_q <= 1'b0;
        end else begin
            state <= state_n;
            if (grant) begin
                sel_ifu <= grant_ifu;
                err_q <= !grant_ok;
                load_q <= grant_ok && (grant_ifu || !bus.lsu_we);
            end
            if (grant_ifu)
                streak <= 4'd0;
            else if (grant_lsu)
                streak <= !bus.ifu_req_valid ? 4'd0 : (streak == LIM ? streak : streak + 4'd1);
        end
    end
endmodule
